// File: rtl/writeback_buffer.sv
// writeback_buffer: FIFO of {rd, data} results draining into the register file write port
//   Yields to decode reads (rd_req) unless the queue has waited STARVE_MAX cycles.
//   Optional bypass lookup of pending results when WB_BYPASS_EN is defined.
//   Ports:
//     clk, rst                         clock, async active-high reset
//     in_valid/in_ready/in_rd/in_data  result push from execute
//     rd_req/rd_stall                  decode read request and its denial
//     rf_write/rf_rd/rf_data           register file write port
//     count                            occupancy
//     q_rs/q_rt, fwd_*_hit/fwd_*_data  bypass lookup of pending entries
module writeback_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_rd,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     rd_req,
   output logic                     rd_stall,
   output logic                     rf_write,
   output logic [ADDR_W-1:0]        rf_rd,
   output logic [DATA_W-1:0]        rf_data,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADDR_W-1:0]        q_rs,
   input  logic [ADDR_W-1:0]        q_rt,
   output logic                     fwd_rs_hit,
   output logic                     fwd_rt_hit,
   output logic [DATA_W-1:0]        fwd_rs_data,
   output logic [DATA_W-1:0]        fwd_rt_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SW    = $clog2(STARVE_MAX + 1);
   logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
   logic [DATA_W-1:0] ent_data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              push, drain;
   always_comb begin
      in_ready = count_q != CNT_W'(DEPTH);
      push     = in_valid && in_ready;
      drain    = (count_q != '0) && (!rd_req || starve_q == SW'(STARVE_MAX));
      rf_write = drain;
      rd_stall = rd_req && drain;
      rf_rd    = ent_rd_q[rd_ptr_q];
      rf_data  = ent_data_q[rd_ptr_q];
      count    = count_q;
      wr_ptr_d = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = drain ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(drain);
      // A non-empty queue that is not draining is necessarily yielding below STARVE_MAX
      starve_d = (drain || count_q == '0) ? '0 : starve_q + SW'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end
   // Entry storage is deliberately left unreset; occupancy alone decides validity
   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd_q[wr_ptr_q]   <= in_rd;
         ent_data_q[wr_ptr_q] <= in_data;
      end
   end
`ifdef WB_BYPASS_EN
   // Scan oldest to newest so the newest match wins; this cycle's push is not yet stored
   always_comb begin
      fwd_rs_hit  = 1'b0;
      fwd_rt_hit  = 1'b0;
      fwd_rs_data = '0;
      fwd_rt_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q && ent_rd_q[rd_ptr_q + PTR_W'(i)] == q_rs) begin
            fwd_rs_hit  = 1'b1;
            fwd_rs_data = ent_data_q[rd_ptr_q + PTR_W'(i)];
         end
         if (CNT_W'(i) < count_q && ent_rd_q[rd_ptr_q + PTR_W'(i)] == q_rt) begin
            fwd_rt_hit  = 1'b1;
            fwd_rt_data = ent_data_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end
`else
   logic unused_q;
   assign unused_q    = ^{q_rs, q_rt};
   assign fwd_rs_hit  = 1'b0;
   assign fwd_rt_hit  = 1'b0;
   assign fwd_rs_data = '0;
   assign fwd_rt_data = '0;
`endif
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: queue-model scoreboard plus directed vectors for writeback_buffer
module tb_writeback_buffer;
   localparam int DEPTH = 4, ADDR_W = 6, DATA_W = 32, STARVE_MAX = 8;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct packed {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;} ent_t;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, rd_req = 1'b0;
   logic [ADDR_W-1:0] in_rd = '0, q_rs = '0, q_rt = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic in_ready, rd_stall, rf_write, fwd_rs_hit, fwd_rt_hit;
   logic [ADDR_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_data, fwd_rs_data, fwd_rt_data;
   logic [$clog2(DEPTH):0] count;
   int n_chk = 0, n_fail = 0;
   ent_t mq[$];
   ent_t wlog[$];
   int yields = 0;
   logic s_write, s_stall, s_hit, s_rthit;
   logic [ADDR_W-1:0] s_rd;
   logic [DATA_W-1:0] s_wdata, s_fdata;
   logic [$clog2(DEPTH):0] s_cnt;

   writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
      .rd_req(rd_req), .rd_stall(rd_stall), .rf_write(rf_write), .rf_rd(rf_rd), .rf_data(rf_data),
      .count(count), .q_rs(q_rs), .q_rt(q_rt), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
      .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state advances at each rising edge; outputs are compared at the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
            yields = 0;
            chk("rst_count", count, 0);
            chk("rst_ready", in_ready, 1);
            chk("rst_write", rf_write, 0);
            chk("rst_stall", rd_stall, 0);
            chk("rst_hits", {fwd_rs_hit, fwd_rt_hit}, 0);
         end else begin
            bit drn, hs, ht;
            logic [DATA_W-1:0] ds, dt;
            drn = mq.size() != 0 && (!rd_req || yields == STARVE_MAX);
            hs = 0; ht = 0; ds = 0; dt = 0;
            if (BYP) begin
               for (int i = mq.size() - 1; i >= 0; i--) begin
                  if (!hs && mq[i].rd == q_rs) begin hs = 1; ds = mq[i].data; end
                  if (!ht && mq[i].rd == q_rt) begin ht = 1; dt = mq[i].data; end
               end
            end
            chk("count", count, mq.size());
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("rf_write", rf_write, drn);
            chk("rd_stall", rd_stall, rd_req && drn);
            if (mq.size() != 0) chk("rf_head", {rf_rd, rf_data}, mq[0]);
            chk("fwd_rs", {fwd_rs_hit, fwd_rs_data}, {hs, ds});
            chk("fwd_rt", {fwd_rt_hit, fwd_rt_data}, {ht, dt});
            if (rf_write) wlog.push_back({rf_rd, rf_data});
         end
         @(posedge clk);
         if (rst) begin
            mq.delete();
            yields = 0;
         end else begin
            bit drn, psh;
            drn = mq.size() != 0 && (!rd_req || yields == STARVE_MAX);
            psh = in_valid && mq.size() < DEPTH;
            if (drn) begin
               void'(mq.pop_front());
               yields = 0;
            end else if (mq.size() != 0) yields++;
            else yields = 0;
            if (psh) mq.push_back({in_rd, in_data});
         end
      end
   end

   task automatic cyc(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input logic req);
      in_valid = v; in_rd = r; in_data = d; rd_req = req;
      #2;
      s_write = rf_write; s_stall = rd_stall; s_rd = rf_rd; s_wdata = rf_data; s_cnt = count;
      s_hit = fwd_rs_hit; s_fdata = fwd_rs_data; s_rthit = fwd_rt_hit;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lsz, nw, p0, p1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      // idle after reset
      chk("t1_count", count, 0);
      chk("t1_ready", in_ready, 1);
      cyc(0, 0, 0, 1);
      chk("t1_stall", s_stall, 0);
      chk("t1_write", s_write, 0);
      // single push drains next cycle
      cyc(1, 5, 32'hDEADBEEF, 0);
      chk("t2_push_write", s_write, 0);
      cyc(0, 0, 0, 0);
      chk("t2_write", s_write, 1);
      chk("t2_rd", s_rd, 5);
      chk("t2_data", s_wdata, 32'hDEADBEEF);
      chk("t2_count", count, 0);
      // fill under read pressure, then bounded starvation
      for (int i = 0; i < 4; i++) cyc(1, ADDR_W'(10 + i), 32'h30 + i, 1);
      chk("t3_full_ready", in_ready, 0);
      chk("t3_full_count", count, 4);
      nw = 0; p0 = -1; p1 = -1;
      for (int k = 0; k < 20; k++) begin
         cyc(0, 0, 0, 1);
         if (s_write) begin
            chk("t3_forced_stall", s_stall, 1);
            if (nw == 0) p0 = k; else if (nw == 1) p1 = k;
            nw++;
         end
      end
      chk("t3_first_force", p0, 5);
      chk("t3_second_force", p1, 14);
      chk("t3_nforce", nw, 2);
      chk("t3_count", count, 2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("t3_log_n", wlog.size(), 5);
      for (int i = 0; i < 4; i++) chk("t3_log", wlog[i + 1], {ADDR_W'(10 + i), 32'h30 + i});
      // same-rd pair: newest wins on bypass, both written in order
      q_rs = 3; q_rt = 7;
      cyc(1, 3, 1, 1);
      cyc(1, 3, 2, 1);
      cyc(0, 0, 0, 1);
      chk("t4_rs_hit", s_hit, BYP);
      chk("t4_rs_data", s_fdata, BYP ? 2 : 0);
      chk("t4_rt_hit", s_rthit, 0);
      lsz = wlog.size();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("t4_log_n", wlog.size(), lsz + 2);
      chk("t4_first", wlog[lsz], {6'd3, 32'd1});
      chk("t4_second", wlog[lsz + 1], {6'd3, 32'd2});
      q_rs = 0; q_rt = 0;
      // streaming with wrap, then reset discards pending entries
      lsz = wlog.size();
      for (int i = 0; i < 10; i++) begin
         cyc(1, ADDR_W'(20 + i), DATA_W'(i), 0);
         if (i > 0) chk("t5_steady", s_cnt, 1);
      end
      cyc(0, 0, 0, 0);
      chk("t5_log_n", wlog.size(), lsz + 10);
      for (int i = 0; i < 10; i++) chk("t5_order", wlog[lsz + i], {ADDR_W'(20 + i), DATA_W'(i)});
      for (int i = 0; i < 3; i++) cyc(1, ADDR_W'(40 + i), 32'h40 + i, 1);
      chk("t5_pending", count, 3);
      #1 rst = 1'b1;
      #1;
      chk("t5_async_count", count, 0);
      chk("t5_async_ready", in_ready, 1);
      chk("t5_async_write", rf_write, 0);
      chk("t5_async_stall", rd_stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      lsz = wlog.size();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("t5_no_write", wlog.size(), lsz);
      chk("t5_final_count", count, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
